// File: rtl/dcache_dma_burst.sv
// Banked data cache with a single-beat execution port and an autonomous DMA burst engine.
// Execution accesses take priority; a DMA beat that collides with exec on its slot stalls.
module dcache_dma_burst #(
    parameter int unsigned NUM_SLOTS = 4,
    parameter int unsigned ADDR_W    = 11,
    parameter int unsigned DATA_W    = 18,
    parameter int unsigned LEN_W     = 11,
    localparam int unsigned SLOT_W   = $clog2(NUM_SLOTS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [SLOT_W-1:0] exec_slot,
    input  logic [ADDR_W-1:0] exec_addr,
    input  logic              exec_we,
    input  logic [DATA_W-1:0] exec_dat_w,
    input  logic              exec_re,
    output logic [DATA_W-1:0] exec_dat_r,
    input  logic              dma_start,
    input  logic              dma_dir,
    input  logic [SLOT_W-1:0] dma_slot,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [LEN_W-1:0]  dma_len,
    output logic              dma_busy,
    input  logic              dma_wvalid,
    output logic              dma_wready,
    input  logic [DATA_W-1:0] dma_dat_w,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] dma_dat_r,
    output logic              dma_done
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StWrBurst = 2'd1;
    localparam logic [1:0] StRdBurst = 2'd2;
    localparam logic [1:0] StDrain   = 2'd3;

    logic [DATA_W-1:0] mem [NUM_SLOTS*DEPTH];

    logic [1:0]        state_q, state_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic              done_q, done_d;
    logic              rvalid_q;
    logic [DATA_W-1:0] dma_dat_r_q;
    logic [DATA_W-1:0] exec_dat_r_q;

    logic [SLOT_W+ADDR_W-1:0] exec_idx, dma_idx;
    logic blocked, wr_beat, rd_beat, last_beat;

    assign exec_idx  = {exec_slot, exec_addr};
    assign dma_idx   = {slot_q, addr_q};
    assign blocked   = (exec_we | exec_re) && (exec_slot == slot_q);
    assign wr_beat   = (state_q == StWrBurst) && dma_wvalid && !blocked;
    assign rd_beat   = (state_q == StRdBurst) && !blocked;
    assign last_beat = (cnt_q == '0);

    assign dma_busy   = (state_q != StIdle);
    assign dma_wready = (state_q == StWrBurst) && !blocked;
    assign dma_rvalid = rvalid_q;
    assign dma_dat_r  = dma_dat_r_q;
    assign dma_done   = done_q;
    assign exec_dat_r = exec_dat_r_q;

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            StIdle: begin
                if (dma_start) begin
                    slot_d  = dma_slot;
                    addr_d  = dma_addr;
                    cnt_d   = dma_len;
                    state_d = dma_dir ? StWrBurst : StRdBurst;
                end
            end
            StWrBurst: begin
                if (wr_beat) begin
                    addr_d = addr_q + 1'b1;
                    cnt_d  = cnt_q - 1'b1;
                    if (last_beat) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                end
            end
            StRdBurst: begin
                // done is registered alongside the last read so it lines up with its rvalid
                if (rd_beat) begin
                    addr_d = addr_q + 1'b1;
                    cnt_d  = cnt_q - 1'b1;
                    if (last_beat) begin
                        state_d = StDrain;
                        done_d  = 1'b1;
                    end
                end
            end
            StDrain: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            slot_q       <= '0;
            addr_q       <= '0;
            cnt_q        <= '0;
            done_q       <= 1'b0;
            rvalid_q     <= 1'b0;
            dma_dat_r_q  <= '0;
            exec_dat_r_q <= '0;
        end else begin
            state_q  <= state_d;
            slot_q   <= slot_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            rvalid_q <= rd_beat;
            if (rd_beat) dma_dat_r_q <= mem[dma_idx];
            if (exec_re) exec_dat_r_q <= mem[exec_idx];
        end
    end

    // Storage is not reset; exec and DMA never write the same slot in one cycle.
    always_ff @(posedge clk) begin
        if (exec_we) mem[exec_idx] <= exec_dat_w;
        if (wr_beat) mem[dma_idx] <= dma_dat_w;
    end

endmodule

// File: doc/dcache_dma_burst.md
Name: dcache_dma_burst

Overview:
- Parametrised next-generation data cache: NUM_SLOTS independent banks of 2^ADDR_W words x DATA_W bits.
- Two ports:
  - Execution port: single-beat read/write from the compute pipeline.
  - DMA port: autonomous burst engine that streams a contiguous address range of one slot in or out.
- Exec has priority on slot conflicts; DMA stalls, never drops beats.

Parameters:
- NUM_SLOTS, 4, number of banks (power of two, >=2); SLOT_W = clog2(NUM_SLOTS) derived.
- ADDR_W, 11, word address width per slot.
- DATA_W, 18, word width.
- LEN_W, 11, burst length field width; beats = dma_len+1.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- exec_slot  in  SLOT_W  exec target slot.
- exec_addr  in  ADDR_W  exec word address.
- exec_we  in  1  exec write enable.
- exec_dat_w  in  DATA_W  exec write data.
- exec_re  in  1  exec read enable.
- exec_dat_r  out  DATA_W  exec read data, 1-cycle latency, held otherwise.
- dma_start  in  1  burst request pulse, sampled only when idle.
- dma_dir  in  1  1 = write into cache, 0 = read out of cache.
- dma_slot  in  SLOT_W  burst slot, latched at start.
- dma_addr  in  ADDR_W  burst start address, latched at start.
- dma_len  in  LEN_W  beats minus one, latched at start.
- dma_busy  out  1  engine not idle.
- dma_wvalid  in  1  write beat data present.
- dma_wready  out  1  write beat accepted this cycle.
- dma_dat_w  in  DATA_W  write beat data.
- dma_rvalid  out  1  read beat data valid.
- dma_dat_r  out  DATA_W  read beat data.
- dma_done  out  1  one-cycle pulse at burst completion.

Behaviour:
- Reset values: exec_dat_r=0, dma_dat_r=0, dma_busy=0, dma_wready=0, dma_rvalid=0, dma_done=0, FSM=IDLE. Memory contents are not reset.
- Exec port:
  - exec_re at edge N -> exec_dat_r holds the word at edge N+1.
  - exec_dat_r keeps its last value while exec_re=0.
  - exec_we and exec_re together, same address: write is performed; read returns the OLD word.
- FSM states:
  - IDLE -> WR_BURST or RD_BURST on dma_start (by dma_dir); latch slot/addr/len; busy=1 from next cycle.
  - WR_BURST -> IDLE after last beat.
  - RD_BURST -> DRAIN after last read issued; DRAIN -> IDLE after the final rvalid.
- Conflict: a DMA beat is blocked in any cycle where (exec_we|exec_re) && exec_slot==latched slot. Different slots run concurrently.
- WR_BURST:
  - dma_wready = !blocked, combinational.
  - Beat transfers when wvalid && wready; writes dma_dat_w at the current address, then increments address and beat counter.
  - dma_done pulses the cycle after the final beat transfers, together with the return to IDLE.
- RD_BURST:
  - Each unblocked cycle issues a read; dma_rvalid and dma_dat_r follow one cycle later. No backpressure on the read side.
  - dma_done is asserted in the same cycle as the final rvalid.
- Address increments modulo 2^ADDR_W (wrap 2^ADDR_W-1 -> 0 within the same slot).
- dma_start while busy: ignored, no effect on the active burst.
- dma_len=0 -> exactly one beat.
- Max burst is 2^LEN_W beats; this may exceed the slot depth, in which case addresses wrap and rewrite.
- dma_dat_r holds its last value when rvalid=0.
- Reset mid-burst: immediate return to IDLE; no done pulse; partially written words remain.
- Exec write and DMA read hitting the same slot: exec wins. DMA reads issued afterwards observe the exec write.

Test Plan:
- Exec: write slot2/addr0=3423; next cycle read -> exec_dat_r=3423. Then we=1 (data 1337), re=0 -> exec_dat_r holds 3423. Read again -> 1337.
- DMA write burst: slot1, addr 0x7FE, len=3, dir=1, data 10,11,12,13 with wvalid constantly 1 -> 4 beats in 4 cycles. Addresses 0x7FE, 0x7FF, 0x000, 0x001. done pulses once. Exec reads confirm the values.
- DMA read burst of the same range, dir=0 -> rvalid for 4 consecutive cycles, data 10,11,12,13. done coincides with the 4th rvalid. busy falls after it.
- Conflict: DMA read burst on slot1 while exec_re on slot1 for 2 cycles mid-burst -> 2-cycle rvalid gap, no beat lost or duplicated. Repeat with exec on slot3 -> no gap.
- Write backpressure: wvalid toggles 1,0,1,1,0,1 for a len=3 burst -> exactly 4 writes in order; done one cycle after the 4th accepted beat.
- Reset mid-burst: assert rst_n=0 after beat 2 of a len=7 write -> busy, wready and done all 0 immediately. A new dma_start after release is accepted normally.
